pipelined_csel_addsub: RTL and testbench



---
 rtl/pipelined_csel_addsub_if.sv | 27 ++
 rtl/pipelined_csel_addsub.sv | 93 +++++++++
 tb/tb_pipelined_csel_addsub.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_csel_addsub_if.sv
// Stream bundle for the pipelined carry-select adder/subtractor.
// The master side produces operand beats and consumes result beats.
interface pipelined_csel_addsub_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din_a;
   logic [WIDTH-1:0] din_b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, din_a, din_b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, din_a, din_b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor: one BLK-bit slice is resolved per stage,
// with both carry-in cases precomputed and selected by the carry registered upstream.
module pipelined_csel_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLK   = 8
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_csel_addsub_if.slave bus
);

   localparam int unsigned NBLK = WIDTH / BLK;

   // Per stage: low k*BLK bits of r_a are resolved sum, upper bits still operand A.
   // The top slice is resolved last, so r_a/r_b MSBs remain the operand MSBs for ovf.
   logic [NBLK-1:0]  r_vld;
   logic [WIDTH-1:0] r_a [NBLK];
   logic [WIDTH-1:0] r_b [NBLK];
   logic [NBLK-1:0]  r_c;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_advance;
   logic             w_accept;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;
   logic [BLK:0]     w_s0    [NBLK];
   logic [BLK:0]     w_s1    [NBLK];
   logic [BLK:0]     w_sel   [NBLK];
   logic [WIDTH-1:0] w_nxt_a [NBLK];
   logic             w_ovf;

   assign w_advance = !r_out_valid || bus.out_ready;
   assign w_accept  = bus.in_valid && w_advance;
   assign w_b_eff   = bus.sub ? ~bus.din_b : bus.din_b;
   assign w_c0      = bus.sub ? ~bus.cin : bus.cin;

   always_comb begin
      for (int unsigned k = 0; k < NBLK; k++) begin
         w_s0[k]    = {1'b0, r_a[k][k*BLK +: BLK]} + {1'b0, r_b[k][k*BLK +: BLK]};
         w_s1[k]    = w_s0[k] + (BLK+1)'(1);
         w_sel[k]   = r_c[k] ? w_s1[k] : w_s0[k];
         w_nxt_a[k] = r_a[k];
         w_nxt_a[k][k*BLK +: BLK] = w_sel[k][BLK-1:0];
      end
   end

   assign w_ovf = (r_a[NBLK-1][WIDTH-1] == r_b[NBLK-1][WIDTH-1]) &&
                  (w_nxt_a[NBLK-1][WIDTH-1] != r_a[NBLK-1][WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld       <= '0;
         r_c         <= '0;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         for (int unsigned k = 0; k < NBLK; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
         end
      end else if (w_advance) begin
         r_vld[0] <= w_accept;
         r_a[0]   <= bus.din_a;
         r_b[0]   <= w_b_eff;
         r_c[0]   <= w_c0;
         for (int unsigned k = 1; k < NBLK; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_a[k]   <= w_nxt_a[k-1];
            r_b[k]   <= r_b[k-1];
            r_c[k]   <= w_sel[k-1][BLK];
         end
         r_out_valid <= r_vld[NBLK-1];
         // Bubbles leave the previous result in place rather than loading junk.
         if (r_vld[NBLK-1]) begin
            r_sum  <= w_nxt_a[NBLK-1];
            r_cout <= w_sel[NBLK-1][BLK];
            r_ovf  <= w_ovf;
         end
      end
   end

   assign bus.in_ready  = w_advance;
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Directed vectors, back-pressure, mid-flight reset and a scoreboarded 16-bit stream.
module tb_pipelined_csel_addsub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_csel_addsub_if #(.WIDTH(32)) b32 ();
   pipelined_csel_addsub_if #(.WIDTH(16)) b16 ();

   pipelined_csel_addsub #(.WIDTH(32), .BLK(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   pipelined_csel_addsub #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
   } beat_t;

   vec_t  vecs [11];
   beat_t beats[$];
   logic [17:0] exp_q[$];

   function automatic logic [17:0] model16(input beat_t t);
      int unsigned ua, ub, ci;
      int          sa, sb, r;
      logic [15:0] s;
      logic        co, ov;
      ua = {16'd0, t.a};
      ub = {16'd0, t.b};
      ci = {31'd0, t.cin};
      sa = int'($signed(t.a));
      sb = int'($signed(t.b));
      if (!t.sub) begin
         s  = 16'(ua + ub + ci);
         co = (ua + ub + ci) > 32'd65535;
         r  = sa + sb + int'(ci);
      end else begin
         s  = 16'(ua - ub - ci);
         co = ua >= (ub + ci);
         r  = sa - sb - int'(ci);
      end
      ov = (r > 32767) || (r < -32768);
      return {ov, co, s};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] cv [5];
      logic        held_v;
      logic [33:0] held;
      int          sent, rcvd, cyc, idx, total;

      vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[5]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
      vecs[6]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
      vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[9]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

      rst = 1'b1;
      b32.in_valid = 1'b0; b32.din_a = '0; b32.din_b = '0; b32.cin = 1'b0; b32.sub = 1'b0;
      b32.out_ready = 1'b1;
      b16.in_valid = 1'b0; b16.din_a = '0; b16.din_b = '0; b16.cin = 1'b0; b16.sub = 1'b0;
      b16.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", {63'd0, b32.out_valid}, 64'd0);
      check("rst_outputs", {29'd0, b32.sum, b32.cout, b32.ovf}, 64'd0);
      check("rst_in_ready", {63'd0, b32.in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with exact-latency check
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         b32.din_a = vecs[i].a; b32.din_b = vecs[i].b;
         b32.cin = vecs[i].cin; b32.sub = vecs[i].sub;
         b32.in_valid = 1'b1;
         @(posedge clk); #1;
         b32.in_valid = 1'b0;
         repeat (3) begin @(posedge clk); #1; end
         check("vec_early", {63'd0, b32.out_valid}, 64'd0);
         @(posedge clk); #1;
         check("vec_valid", {63'd0, b32.out_valid}, 64'd1);
         check("vec_result", {30'd0, b32.sum, b32.cout, b32.ovf},
               {30'd0, vecs[i].s, vecs[i].co, vecs[i].ov});
      end

      // Back-pressure: out_ready pattern 1,0,0,1
      sent = 0; rcvd = 0; cyc = 0; held_v = 1'b0; held = '0;
      while (rcvd < 10 && cyc < 200) begin
         @(posedge clk); #1;
         b32.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 10) begin
            b32.in_valid = 1'b1;
            b32.din_a = 32'(sent); b32.din_b = 32'(2 * sent);
            b32.cin = 1'b0; b32.sub = 1'b0;
         end else begin
            b32.in_valid = 1'b0;
         end
         @(negedge clk);
         if (held_v)
            check("bp_hold", {30'd0, b32.sum, b32.cout, b32.ovf}, {30'd0, held});
         check("bp_in_ready", {63'd0, b32.in_ready},
               {63'd0, !(b32.out_valid && !b32.out_ready)});
         if (b32.in_valid && b32.in_ready) sent++;
         held_v = b32.out_valid && !b32.out_ready;
         held   = {b32.sum, b32.cout, b32.ovf};
         if (b32.out_valid && b32.out_ready) begin
            check("bp_sum", {32'd0, b32.sum}, 64'(3 * rcvd));
            rcvd++;
         end
         cyc++;
      end
      check("bp_count", 64'(rcvd), 64'd10);
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      b32.out_ready = 1'b1;
      repeat (6) @(posedge clk);

      // Reset mid-flight
      #1;
      for (int j = 0; j < 3; j++) begin
         b32.in_valid = 1'b1;
         b32.din_a = 32'h11111111 * 32'(j + 1); b32.din_b = 32'h22222222;
         b32.cin = 1'b0; b32.sub = 1'b0;
         @(posedge clk); #1;
      end
      b32.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      check("rst_pre_valid", {63'd0, b32.out_valid}, 64'd1);
      check("rst_pre_sum", {32'd0, b32.sum}, 64'h33333333);
      #1 rst = 1'b1;
      #1;
      check("rst_now_valid", {63'd0, b32.out_valid}, 64'd0);
      check("rst_now_outputs", {29'd0, b32.sum, b32.cout, b32.ovf}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("rst_no_stale", {63'd0, b32.out_valid}, 64'd0);
      end

      // 16-bit corners plus random stream with random back-pressure
      cv = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      for (int ia = 0; ia < 5; ia++)
         for (int ib = 0; ib < 5; ib++)
            for (int m = 0; m < 4; m++)
               beats.push_back('{cv[ia], cv[ib], m[0], m[1]});
      for (int j = 0; j < 200; j++)
         beats.push_back('{16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)});
      total = beats.size();
      idx = 0; rcvd = 0; cyc = 0;
      while (rcvd < total && cyc < 5000) begin
         @(posedge clk); #1;
         if (idx < total) begin
            b16.din_a = beats[idx].a; b16.din_b = beats[idx].b;
            b16.cin = beats[idx].cin; b16.sub = beats[idx].sub;
            b16.in_valid = 1'b1;
         end else begin
            b16.in_valid = 1'b0;
         end
         b16.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (b16.in_valid && b16.in_ready) begin
            exp_q.push_back(model16(beats[idx]));
            idx++;
         end
         if (b16.out_valid && b16.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL r16_extra: got %h, required no beat", {b16.ovf, b16.cout, b16.sum});
            end else begin
               check("r16", {46'd0, b16.ovf, b16.cout, b16.sum}, {46'd0, exp_q.pop_front()});
            end
            rcvd++;
         end
         cyc++;
      end
      check("r16_count", 64'(rcvd), 64'(total));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
